// File: rtl/ternary_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module : ternary_dot_accumulator
// Brief  : Ternary-weight dot product with a saturating accumulator and a
//          2-deep valid/ready result queue.
// Rev    : 1.0  initial release
// ============================================================================
module ternary_dot_accumulator #(
  parameter int ACT_W = 8,
  parameter int ACC_W = 20,
  parameter int LEN   = 256
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_in,
  input  logic             valid_in,
  input  logic [ACT_W-1:0] act_in,
  input  logic [1:0]       weight_in,
  input  logic             last_in,
  output logic [ACC_W-1:0] sum_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             overflow_out,
  output logic             len_err_out,
  output logic             sat_out
);

  localparam int               CNT_W      = $clog2(LEN);
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(LEN - 1);
  localparam logic [ACC_W-1:0] C_MAX      = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] C_MIN      = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [ACC_W-1:0] r_head;
  logic [ACC_W-1:0] r_tail;
  logic [1:0]       r_fill;
  logic             r_ovf;
  logic             r_len_err;
  logic             r_sat;

  logic [ACC_W-1:0] w_act_ext;
  logic [ACC_W-1:0] w_prod;
  logic [ACC_W:0]   w_wide;
  logic             w_clamp;
  logic [ACC_W-1:0] w_nxt;
  logic             w_at_last;
  logic             w_push;
  logic             w_pop;

  assign w_act_ext = {{(ACC_W-ACT_W){act_in[ACT_W-1]}}, act_in};

  // Negation happens at ACC_W, so the most negative activation negates exactly.
  always_comb begin
    w_prod = '0;
    case (weight_in)
      2'b01:   w_prod = w_act_ext;
      2'b11:   w_prod = -w_act_ext;
      default: w_prod = '0;
    endcase
  end

  assign w_wide    = {r_acc[ACC_W-1], r_acc} + {w_prod[ACC_W-1], w_prod};
  assign w_clamp   = w_wide[ACC_W] ^ w_wide[ACC_W-1];
  assign w_nxt     = w_clamp ? (w_wide[ACC_W] ? C_MIN : C_MAX) : w_wide[ACC_W-1:0];
  assign w_at_last = (r_count == C_LAST_IDX);
  assign w_push    = valid_in & (w_at_last | last_in);
  assign w_pop     = (r_fill != 2'd0) & ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_len_err <= 1'b0;
      r_sat     <= 1'b0;
    end else if (clear_in) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_len_err <= 1'b0;
      r_sat     <= 1'b0;
    end else if (valid_in) begin
      if (w_push) begin
        r_acc   <= '0;
        r_count <= '0;
      end else begin
        r_acc   <= w_nxt;
        r_count <= r_count + 1'b1;
      end
      if (w_clamp)
        r_sat <= 1'b1;
      if (last_in != w_at_last)
        r_len_err <= 1'b1;
    end
  end

  // Head register keeps its value after the final pop so sum_out holds.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head <= '0;
      r_tail <= '0;
      r_fill <= 2'd0;
      r_ovf  <= 1'b0;
    end else if (clear_in) begin
      r_head <= '0;
      r_tail <= '0;
      r_fill <= 2'd0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_pop && r_fill == 2'd2)
        r_head <= r_tail;
      if (w_push) begin
        if (r_fill == 2'd0 || (r_fill == 2'd1 && w_pop))
          r_head <= w_nxt;
        else if (r_fill == 2'd1 || w_pop)
          r_tail <= w_nxt;
        else
          r_ovf <= 1'b1;
      end
      if (w_push && !w_pop && r_fill != 2'd2)
        r_fill <= r_fill + 2'd1;
      else if (!w_push && w_pop)
        r_fill <= r_fill - 2'd1;
    end
  end

  assign sum_out      = r_head;
  assign valid_out    = (r_fill != 2'd0);
  assign overflow_out = r_ovf;
  assign len_err_out  = r_len_err;
  assign sat_out      = r_sat;

endmodule
`default_nettype wire
